led_matrix_scanner: RTL

Drives the physical 16x16 bicolor LED board from the parallel `RedPixels`/`GrnPixels` frame produced by the game/pattern logic. It scans one row at a time: it shifts that row's column data serially into the board's red and green shift registers, latches the data, selects the row and lights it for a fixed dwell time. All sixteen rows are refreshed this way in a continuous loop. It sits between the frame-producing logic and the board connector pins.

---
 rtl/led_matrix_pkg.sv | 26 ++
 rtl/led_matrix_scanner_if.sv | 31 +++
 rtl/led_row_serializer.sv | 83 ++++++++
 rtl/led_matrix_scanner.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/led_matrix_pkg.sv
// Shared types and constants for the 16x16 bicolor LED matrix scanner.
//   MATRIX_N      : rows/columns on the board
//   pixel_frame_t : [row][col] frame, 1 = lit
//   pixel_row_t   : one row of column bits
//   row_idx_t     : row / bit index width
//   scan_state_t  : scan FSM states
package led_matrix_pkg;

  localparam int MATRIX_N = 16;
  localparam int IDX_W    = $clog2(MATRIX_N);

  typedef logic [MATRIX_N-1:0][MATRIX_N-1:0] pixel_frame_t;
  typedef logic [MATRIX_N-1:0]               pixel_row_t;
  typedef logic [IDX_W-1:0]                  row_idx_t;

  localparam row_idx_t LAST_IDX = row_idx_t'(MATRIX_N - 1);

  typedef enum logic [2:0] {
    LOAD     = 3'd0,
    SHIFT_LO = 3'd1,
    SHIFT_HI = 3'd2,
    LATCH    = 3'd3,
    DISPLAY  = 3'd4
  } scan_state_t;

endpackage

// File: rtl/led_matrix_scanner_if.sv
// Bundle between the frame producer, the scanner and the board connector.
//   RedPixels/GrnPixels : parallel frames from the game/pattern logic
//   SerR/SerG/SrClk     : serial column data and shift clock to the board
//   RClk                : storage-register latch pulse
//   RowSel/OE_n         : active row and active-low output enable
//   FrameDone           : one-cycle end-of-frame pulse
// master = scanner side, slave = producer/board side.
interface led_matrix_scanner_if;
  import led_matrix_pkg::*;

  pixel_frame_t RedPixels;
  pixel_frame_t GrnPixels;
  logic         SerR;
  logic         SerG;
  logic         SrClk;
  logic         RClk;
  row_idx_t     RowSel;
  logic         OE_n;
  logic         FrameDone;

  modport master (
    input  RedPixels, GrnPixels,
    output SerR, SerG, SrClk, RClk, RowSel, OE_n, FrameDone
  );

  modport slave (
    output RedPixels, GrnPixels,
    input  SerR, SerG, SrClk, RClk, RowSel, OE_n, FrameDone
  );

endinterface

// File: rtl/led_row_serializer.sv
// Shifts one red/green row pair out MSB (column 15) first.
//   CLK, RST  : clock, synchronous active-high reset
//   start     : load red_row/grn_row and begin a 16-bit shift sequence
//   red_row   : red column bits of the row
//   grn_row   : green column bits of the row
//   red_ser   : registered serial red data
//   grn_ser   : registered serial green data
//   shift_clk : registered shift clock, low one cycle then high one cycle per bit
//   done      : high during the 16th shift_clk high phase
module led_row_serializer
  import led_matrix_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  pixel_row_t red_row,
  input  pixel_row_t grn_row,
  output logic       red_ser,
  output logic       grn_ser,
  output logic       shift_clk,
  output logic       done
);

  pixel_row_t red_sh_r;
  pixel_row_t grn_sh_r;
  row_idx_t   bit_r;
  logic       active_r;
  logic       red_ser_r;
  logic       grn_ser_r;
  logic       shift_clk_r;
  logic       done_r;

  // Shift sequencer: the shift_clk register doubles as the low/high phase flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      red_sh_r    <= '0;
      grn_sh_r    <= '0;
      bit_r       <= '0;
      active_r    <= 1'b0;
      red_ser_r   <= 1'b0;
      grn_ser_r   <= 1'b0;
      shift_clk_r <= 1'b0;
      done_r      <= 1'b0;
    end else if (start) begin
      // Column 15 goes out first, presented during the first low phase.
      red_sh_r    <= red_row;
      grn_sh_r    <= grn_row;
      red_ser_r   <= red_row[MATRIX_N-1];
      grn_ser_r   <= grn_row[MATRIX_N-1];
      bit_r       <= '0;
      active_r    <= 1'b1;
      shift_clk_r <= 1'b0;
      done_r      <= 1'b0;
    end else if (active_r) begin
      if (!shift_clk_r) begin
        // Rising edge to the board; data is held through the high phase.
        shift_clk_r <= 1'b1;
        done_r      <= (bit_r == LAST_IDX);
      end else begin
        shift_clk_r <= 1'b0;
        done_r      <= 1'b0;
        if (bit_r == LAST_IDX) begin
          active_r <= 1'b0;
          bit_r    <= '0;
        end else begin
          bit_r     <= bit_r + 4'd1;
          red_sh_r  <= red_sh_r << 1;
          grn_sh_r  <= grn_sh_r << 1;
          red_ser_r <= red_sh_r[MATRIX_N-2];
          grn_ser_r <= grn_sh_r[MATRIX_N-2];
        end
      end
    end else begin
      done_r <= 1'b0;
    end
  end

  assign red_ser   = red_ser_r;
  assign grn_ser   = grn_ser_r;
  assign shift_clk = shift_clk_r;
  assign done      = done_r;

endmodule

// File: rtl/led_matrix_scanner.sv
// Row-scanning driver for the 16x16 bicolor LED board.
//   DWELL : cycles each row is lit (1..65535)
//   CLK   : system clock
//   RST   : synchronous active-high reset
//   bus   : led_matrix_scanner_if.master (frames in, board pins and FrameDone out)
// Each frame: LOAD snapshots both frames, then per row 32 shift cycles,
// one LATCH cycle and DWELL DISPLAY cycles. The board is blanked outside DISPLAY.
module led_matrix_scanner
  import led_matrix_pkg::*;
#(
  parameter int unsigned DWELL = 1024
)(
  input  logic                  CLK,
  input  logic                  RST,
  led_matrix_scanner_if.master  bus
);

  localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);

  scan_state_t  state_r;
  scan_state_t  state_next_s;
  row_idx_t     row_r;
  row_idx_t     row_next_s;
  logic [15:0]  dwell_r;
  logic [15:0]  dwell_next_s;
  pixel_frame_t snap_red_r;
  pixel_frame_t snap_grn_r;
  logic         rclk_r;
  row_idx_t     row_sel_r;
  logic         oe_n_r;
  logic         frame_done_r;
  logic         dwell_last_s;
  logic         ser_start_s;
  pixel_row_t   ser_red_s;
  pixel_row_t   ser_grn_s;
  logic         ser_done_s;
  logic         red_ser_s;
  logic         grn_ser_s;
  logic         shift_clk_s;

  assign dwell_last_s = (dwell_r == DWELL_LAST);

  // Next-state, counter and serializer-start decode.
  always_comb begin
    state_next_s = state_r;
    row_next_s   = row_r;
    dwell_next_s = dwell_r;
    ser_start_s  = 1'b0;
    case (state_r)
      LOAD: begin
        state_next_s = SHIFT_LO;
        row_next_s   = '0;
        dwell_next_s = '0;
        ser_start_s  = 1'b1;
      end
      SHIFT_LO: begin
        state_next_s = SHIFT_HI;
      end
      SHIFT_HI: begin
        if (ser_done_s) begin
          state_next_s = LATCH;
        end else begin
          state_next_s = SHIFT_LO;
        end
      end
      LATCH: begin
        state_next_s = DISPLAY;
        dwell_next_s = '0;
      end
      DISPLAY: begin
        if (dwell_last_s) begin
          dwell_next_s = '0;
          if (row_r == LAST_IDX) begin
            state_next_s = LOAD;
          end else begin
            state_next_s = SHIFT_LO;
            row_next_s   = row_r + 4'd1;
            ser_start_s  = 1'b1;
          end
        end else begin
          dwell_next_s = dwell_r + 16'd1;
        end
      end
      default: begin
        state_next_s = LOAD;
        row_next_s   = '0;
        dwell_next_s = '0;
      end
    endcase
  end

  // Row fed to the serializer. Row 0 of a new frame comes straight from the
  // inputs because the snapshot is only being written on that same edge.
  always_comb begin
    if (state_r == LOAD) begin
      ser_red_s = bus.RedPixels[0];
      ser_grn_s = bus.GrnPixels[0];
    end else begin
      ser_red_s = snap_red_r[row_next_s];
      ser_grn_s = snap_grn_r[row_next_s];
    end
  end

  // FSM state and row/dwell counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= LOAD;
      row_r   <= '0;
      dwell_r <= '0;
    end else begin
      state_r <= state_next_s;
      row_r   <= row_next_s;
      dwell_r <= dwell_next_s;
    end
  end

  // Frame snapshot, taken only in LOAD so a frame never tears.
  always_ff @(posedge CLK) begin
    if (RST) begin
      snap_red_r <= '0;
      snap_grn_r <= '0;
    end else if (state_r == LOAD) begin
      snap_red_r <= bus.RedPixels;
      snap_grn_r <= bus.GrnPixels;
    end else begin
      snap_red_r <= snap_red_r;
      snap_grn_r <= snap_grn_r;
    end
  end

  // Board control outputs, registered from the next state so they line up
  // with the state they describe.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rclk_r       <= 1'b0;
      row_sel_r    <= '0;
      oe_n_r       <= 1'b1;
      frame_done_r <= 1'b0;
    end else begin
      rclk_r       <= (state_next_s == LATCH);
      oe_n_r       <= (state_next_s != DISPLAY);
      // Row does not change on entry to or within DISPLAY, so row_r is the displayed row.
      frame_done_r <= (state_next_s == DISPLAY) && (dwell_next_s == DWELL_LAST) &&
                      (row_r == LAST_IDX);
      if ((state_next_s == LATCH) || (state_next_s == DISPLAY)) begin
        row_sel_r <= row_next_s;
      end else begin
        row_sel_r <= row_sel_r;
      end
    end
  end

  led_row_serializer u_ser (
    .CLK       (CLK),
    .RST       (RST),
    .start     (ser_start_s),
    .red_row   (ser_red_s),
    .grn_row   (ser_grn_s),
    .red_ser   (red_ser_s),
    .grn_ser   (grn_ser_s),
    .shift_clk (shift_clk_s),
    .done      (ser_done_s)
  );

  assign bus.SerR      = red_ser_s;
  assign bus.SerG      = grn_ser_s;
  assign bus.SrClk     = shift_clk_s;
  assign bus.RClk      = rclk_r;
  assign bus.RowSel    = row_sel_r;
  assign bus.OE_n      = oe_n_r;
  assign bus.FrameDone = frame_done_r;

endmodule
